// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states, the
// stall/flush control bundle and the normal-flow priority decode.
package common_def;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALT     = 2'd3
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic flush_ifid;
    logic flush_idex;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE = '{default: 1'b0};

  localparam hz_ctrl_t CTRL_STALL_ALL = '{
    stall_pc:    1'b1,
    stall_ifid:  1'b1,
    stall_idex:  1'b1,
    stall_exmem: 1'b1,
    flush_ifid:  1'b0,
    flush_idex:  1'b0
  };

  // Normal-flow decode once memory is not busy: ECALL, then redirect, then
  // load-use. A redirect discards load-use because the consumer is flushed.
  function automatic hz_ctrl_t run_decode(input logic ecall, input logic branch_taken,
                                          input logic load_use);
    hz_ctrl_t c;
    c = CTRL_NONE;
    if (ecall) begin
      c.stall_pc   = 1'b1;
      c.flush_ifid = 1'b1;
      c.flush_idex = 1'b1;
    end else if (branch_taken) begin
      c.flush_ifid = 1'b1;
      c.flush_idex = 1'b1;
    end else if (load_use) begin
      c.stall_pc   = 1'b1;
      c.stall_ifid = 1'b1;
      c.flush_idex = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave): hazard sources in, stall/flush controls and status out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
) ();
  import common_def::*;

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memRead;
  logic             ex_branch_taken;
  logic             ex_ecall;
  // dmem_req/dmem_ack: an access is pending while dmem_req=1; it completes
  // in the cycle dmem_ack=1. req=1 with ack=0 is the only "busy" condition.
  logic             dmem_req;
  logic             dmem_ack;

  logic             stall_pc;
  logic             stall_ifid;
  logic             stall_idex;
  logic             stall_exmem;
  logic             flush_ifid;
  logic             flush_idex;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  hz_state_t        dbg_state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memRead,
           ex_branch_taken, ex_ecall, dmem_req, dmem_ack,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
           halted, mem_timeout, stall_cycles, dbg_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memRead,
           ex_branch_taken, ex_ecall, dmem_req, dmem_ack,
    output stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
           halted, mem_timeout, stall_cycles, dbg_state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: the ID instruction reads the register an EX load is
// about to write. x0 is never a hazard.
module hazard_detect
  import common_def::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_memRead_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_memRead_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, redirect
// flushes, data-memory waits and ECALL drain-to-halt, plus stall statistics.
module pipeline_hazard_ctrl
  import common_def::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);
  localparam logic [3:0] DRAIN_LAST  = 4'(DRAIN_CYCLES - 1);

  hz_state_t        state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [3:0]       drain_cnt_q, drain_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  hz_ctrl_t ctrl;
  logic     load_use;
  logic     mem_busy;

  hazard_detect u_hazard_detect (
    .id_rs1_i      (hz.id_rs1),
    .id_rs2_i      (hz.id_rs2),
    .id_uses_rs1_i (hz.id_uses_rs1),
    .id_uses_rs2_i (hz.id_uses_rs2),
    .ex_rd_i       (hz.ex_rd),
    .ex_memRead_i  (hz.ex_memRead),
    .load_use_o    (load_use)
  );

  assign mem_busy = hz.dmem_req && !hz.dmem_ack;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    mem_timeout_d = mem_timeout_q;
    ctrl          = CTRL_NONE;

    case (state_q)
      RUN: begin
        if (mem_busy) begin
          ctrl       = CTRL_STALL_ALL;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          ctrl = run_decode(hz.ex_ecall, hz.ex_branch_taken, load_use);
          if (hz.ex_ecall) begin
            state_d     = DRAIN;
            drain_cnt_d = 4'd0;
          end
        end
      end

      MEM_WAIT: begin
        if (hz.dmem_ack) begin
          // The ack cycle releases the pipe and behaves like a quiet RUN cycle.
          ctrl       = run_decode(hz.ex_ecall, hz.ex_branch_taken, load_use);
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          ctrl = CTRL_STALL_ALL;
          if (wait_cnt_q < TIMEOUT_LIM) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
          if (wait_cnt_d == TIMEOUT_LIM) begin
            mem_timeout_d = 1'b1;
          end
        end
      end

      DRAIN: begin
        ctrl.stall_pc   = 1'b1;
        ctrl.flush_ifid = 1'b1;
        ctrl.flush_idex = 1'b1;
        if (mem_busy) begin
          // Let the older instructions finish their access before counting on.
          ctrl.stall_exmem = 1'b1;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = HALT;
          drain_cnt_d = 4'd0;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end

      HALT: begin
        ctrl.stall_pc   = 1'b1;
        ctrl.flush_ifid = 1'b1;
        ctrl.flush_idex = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    stall_cycles_d = stall_cycles_q;
    if (ctrl.stall_pc && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= 8'd0;
      drain_cnt_q    <= 4'd0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.stall_pc     = ctrl.stall_pc;
  assign hz.stall_ifid   = ctrl.stall_ifid;
  assign hz.stall_idex   = ctrl.stall_idex;
  assign hz.stall_exmem  = ctrl.stall_exmem;
  assign hz.flush_ifid   = ctrl.flush_ifid;
  assign hz.flush_idex   = ctrl.flush_idex;
  assign hz.halted       = (state_q == HALT);
  assign hz.mem_timeout  = mem_timeout_q;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.dbg_state    = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (default timeout and
// MEM_TIMEOUT=3) share the same stimulus; outputs are checked every cycle.
module tb_pipeline_hazard_ctrl;
  import common_def::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) if_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(32)) if_b ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(255), .CNT_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (if_a.slave)
  );

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(3), .CNT_W(32)) u_dut_to (
    .clk (clk),
    .rst (rst),
    .hz  (if_b.slave)
  );

  assign if_b.id_rs1          = if_a.id_rs1;
  assign if_b.id_rs2          = if_a.id_rs2;
  assign if_b.id_uses_rs1     = if_a.id_uses_rs1;
  assign if_b.id_uses_rs2     = if_a.id_uses_rs2;
  assign if_b.ex_rd           = if_a.ex_rd;
  assign if_b.ex_memRead      = if_a.ex_memRead;
  assign if_b.ex_branch_taken = if_a.ex_branch_taken;
  assign if_b.ex_ecall        = if_a.ex_ecall;
  assign if_b.dmem_req        = if_a.dmem_req;
  assign if_b.dmem_ack        = if_a.dmem_ack;

  // Expected word: {stall_pc, stall_ifid, stall_idex, stall_exmem,
  //                 flush_ifid, flush_idex, halted, mem_timeout}
  localparam logic [7:0] E_NONE    = 8'b0000_0000;
  localparam logic [7:0] E_LU      = 8'b1100_0100;
  localparam logic [7:0] E_BR      = 8'b0000_1100;
  localparam logic [7:0] E_MEM     = 8'b1111_0000;
  localparam logic [7:0] E_DRN     = 8'b1000_1100;
  localparam logic [7:0] E_DRN_MEM = 8'b1001_1100;
  localparam logic [7:0] E_HALT    = 8'b1000_1110;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       ec;
    logic       req;
    logic       ack;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] act_word();
    return {if_a.stall_pc, if_a.stall_ifid, if_a.stall_idex, if_a.stall_exmem,
            if_a.flush_ifid, if_a.flush_idex, if_a.halted, if_a.mem_timeout};
  endfunction

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                             input logic u2, input logic [4:0] rd, input logic mr,
                             input logic br, input logic ec, input logic req, input logic ack);
    in_t v;
    v.rst = 1'b0; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.br = br; v.ec = ec; v.req = req; v.ack = ack;
    return v;
  endfunction

  function automatic in_t idle(input logic r);
    in_t v;
    v = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v.rst = r;
    return v;
  endfunction

  // Independent RUN-state expectation for inputs without ECALL or memory activity.
  function automatic logic [7:0] model_run(input in_t v);
    logic hit;
    hit = v.mr && (v.rd != 5'd0) &&
          ((v.u1 && (v.rs1 == v.rd)) || (v.u2 && (v.rs2 == v.rd)));
    if (v.br) return E_BR;
    if (hit)  return E_LU;
    return E_NONE;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input in_t v);
    rst                  = v.rst;
    if_a.id_rs1          = v.rs1;
    if_a.id_rs2          = v.rs2;
    if_a.id_uses_rs1     = v.u1;
    if_a.id_uses_rs2     = v.u2;
    if_a.ex_rd           = v.rd;
    if_a.ex_memRead      = v.mr;
    if_a.ex_branch_taken = v.br;
    if_a.ex_ecall        = v.ec;
    if_a.dmem_req        = v.req;
    if_a.dmem_ack        = v.ack;
  endtask

  task automatic idle_cycle(input in_t v);
    @(posedge clk); #1;
    apply(v);
  endtask

  task automatic run_cycle(input string name, input in_t v, input logic [7:0] exp);
    logic [7:0] e;
    @(posedge clk); #1;
    apply(v);
    exp_q.push_back(exp);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'd0, act_word()}, {24'd0, e});
    end
  endtask

  task automatic do_reset();
    idle_cycle(idle(1'b1));
    idle_cycle(idle(1'b1));
  endtask

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_t v;
    apply(idle(1'b1));

    tbl[0]  = '{"idle",         mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0), E_NONE};
    tbl[1]  = '{"lu_rs2",       mk(5'd1,  5'd5,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0), E_LU};
    tbl[2]  = '{"lu_rs1",       mk(5'd5,  5'd9,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0), E_LU};
    tbl[3]  = '{"rs1_unused",   mk(5'd5,  5'd9,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0), E_NONE};
    tbl[4]  = '{"x0_load",      mk(5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0), E_NONE};
    tbl[5]  = '{"not_load",     mk(5'd5,  5'd5,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0), E_NONE};
    tbl[6]  = '{"lu_and_br",    mk(5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0), E_BR};
    tbl[7]  = '{"branch",       mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0), E_BR};
    tbl[8]  = '{"lu_rs2_x7",    mk(5'd3,  5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0), E_LU};
    tbl[9]  = '{"lu_req_ack",   mk(5'd4,  5'd0,  1'b1, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1), E_LU};
    tbl[10] = '{"rs2_unused31", mk(5'd2,  5'd31, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), E_NONE};

    // Reset state
    do_reset();
    run_cycle("reset_outputs", idle(1'b1), E_NONE);
    check("reset_stall_cycles", if_a.stall_cycles, 32'd0);
    check("reset_state", 32'(if_a.dbg_state), 32'(RUN));
    check("reset_timeout_b", {31'd0, if_b.mem_timeout}, 32'd0);

    // Table-driven RUN-state vectors
    for (int i = 0; i < 11; i++) begin
      run_cycle(tbl[i].name, tbl[i].in, tbl[i].exp);
    end

    // Random RUN-state vectors against the bench model
    for (int i = 0; i < 16; i++) begin
      v = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      run_cycle("rand_run", v, model_run(v));
    end
    check("rand_state", 32'(if_a.dbg_state), 32'(RUN));

    // Load-use: exactly one bubble
    do_reset();
    run_cycle("lu_bubble", mk(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), E_LU);
    run_cycle("lu_release", mk(5'd1, 5'd5, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), E_NONE);
    check("lu_stall_cycles", if_a.stall_cycles, 32'd1);

    // Memory wait: 4 busy cycles then ack
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_cycle("mem_busy", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_MEM);
    end
    run_cycle("mem_ack", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), E_NONE);
    run_cycle("mem_after", idle(1'b0), E_NONE);
    check("mem_state", 32'(if_a.dbg_state), 32'(RUN));
    check("mem_stall_cycles", if_a.stall_cycles, 32'd4);

    // Timeout on the MEM_TIMEOUT=3 instance: 6 busy cycles, then ack
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      v = idle(1'b0);
      v.req = (c <= 7);
      v.ack = (c == 7);
      run_cycle("to_a_word", v, (c <= 6) ? E_MEM : E_NONE);
      check($sformatf("to_b_flag_c%0d", c), {31'd0, if_b.mem_timeout}, {31'd0, (c >= 4)});
    end
    check("to_b_state", 32'(if_b.dbg_state), 32'(RUN));

    // Reset during MEM_WAIT
    run_cycle("rmw_busy1", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_MEM);
    run_cycle("rmw_busy2", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_MEM);
    v = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    v.rst = 1'b1;
    idle_cycle(v);
    run_cycle("rmw_after", idle(1'b0), E_NONE);
    check("rmw_stall_cycles", if_a.stall_cycles, 32'd0);
    check("rmw_timeout_b", {31'd0, if_b.mem_timeout}, 32'd0);
    check("rmw_state", 32'(if_a.dbg_state), 32'(RUN));

    // ECALL: 1 + 3 drain cycles, then halted for 20 cycles
    do_reset();
    run_cycle("ecall", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), E_DRN);
    for (int i = 0; i < 3; i++) begin
      run_cycle("drain", idle(1'b0), E_DRN);
    end
    for (int i = 0; i < 20; i++) begin
      run_cycle("halt", idle(1'b0), E_HALT);
      if (i == 0)  check("halt_sc_first", if_a.stall_cycles, 32'd4);
      if (i == 19) check("halt_sc_last", if_a.stall_cycles, 32'd23);
    end

    // Reset during HALT
    idle_cycle(idle(1'b1));
    run_cycle("rh_after", idle(1'b0), E_NONE);
    check("rh_stall_cycles", if_a.stall_cycles, 32'd0);
    check("rh_state", 32'(if_a.dbg_state), 32'(RUN));

    // Drain held by a memory wait; redirect and load-use ignored while draining
    do_reset();
    run_cycle("dm_ecall", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), E_DRN);
    run_cycle("dm_busy", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_DRN_MEM);
    run_cycle("dm_br_lu", mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), E_DRN);
    run_cycle("dm_drain2", idle(1'b0), E_DRN);
    run_cycle("dm_drain3", idle(1'b0), E_DRN);
    run_cycle("dm_halt", idle(1'b0), E_HALT);
    check("dm_stall_cycles", if_a.stall_cycles, 32'd5);
    check("dm_state", 32'(if_a.dbg_state), 32'(HALT));

    // ---------------- final report ----------------
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the stall and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC enable.
- Resolves load-use hazards, taken-branch/jump redirects, multi-cycle data-memory waits, and ECALL pipeline drain-to-halt.
- Keeps a saturating stall-cycle performance counter and a sticky memory-timeout flag.

Parameters:
- DRAIN_CYCLES, 3, cycles held in DRAIN after ECALL reaches EX before entering HALT (range 1..15).
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before mem_timeout sets (range 1..255).
- CNT_W, 32, width of stall_cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- id_rs1  in  5  source register 1 of the instruction in ID
- id_rs2  in  5  source register 2 of the instruction in ID
- id_uses_rs1  in  1  the ID instruction reads rs1
- id_uses_rs2  in  1  the ID instruction reads rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_memRead  in  1  the EX instruction is a load
- ex_branch_taken  in  1  the EX instruction redirects the PC
- ex_ecall  in  1  the EX instruction is ECALL
- dmem_req  in  1  MEM stage has an active data-memory access
- dmem_ack  in  1  data memory completes the access this cycle
- stall_pc  out  1  hold the PC
- stall_ifid  out  1  hold IF/ID
- stall_idex  out  1  hold ID/EX
- stall_exmem  out  1  hold EX/MEM
- flush_ifid  out  1  load a NOP into IF/ID
- flush_idex  out  1  load a bubble (NOP, controls zero) into ID/EX
- halted  out  1  core halted after ECALL
- mem_timeout  out  1  sticky; a MEM_WAIT exceeded MEM_TIMEOUT
- stall_cycles  out  CNT_W  count of cycles with stall_pc=1, saturating at all-ones

Behaviour:
- Only these are registered: the state (RUN, MEM_WAIT, DRAIN, HALT), wait_cnt[7:0], drain_cnt[3:0], mem_timeout and stall_cycles.
- All stall/flush outputs are combinational from state and inputs, so they take effect in the same cycle.
- rst (sampled on the clk edge):
  - state=RUN; all counters 0; mem_timeout=0; halted=0.
  - With inputs at 0, every output is 0.
  - rst asserted mid-operation (any state) takes effect at the next edge and overrides every other event.
- load_use = ex_memRead & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- x0 never causes a hazard.
- mem_busy = dmem_req & ~dmem_ack.
- RUN, evaluated in priority order; the first match applies:
  1. mem_busy: all four stalls=1, no flushes; next state MEM_WAIT with wait_cnt=1.
  2. ex_ecall: stall_pc=1, flush_ifid=1, flush_idex=1; next state DRAIN with drain_cnt=0.
  3. ex_branch_taken: flush_ifid=1, flush_idex=1, no stalls. A simultaneous load_use is discarded, because the dependent instruction is flushed.
  4. load_use: stall_pc=1, stall_ifid=1, flush_idex=1. This is a one-bubble stall; the instruction re-evaluates next cycle, when the load has moved to MEM.
  5. Otherwise all outputs are 0.
- MEM_WAIT:
  - All four stalls=1, flushes=0.
  - dmem_ack=1: outputs the same as RUN with mem_busy=0 in this cycle; next state RUN; wait_cnt=0.
  - Otherwise wait_cnt increments. When wait_cnt reaches MEM_TIMEOUT, mem_timeout sets and the counter holds at MEM_TIMEOUT.
  - The block keeps waiting for the ack; there is no abort.
- DRAIN:
  - stall_pc=1, flush_ifid=1, flush_idex=1, stalls on IF/ID and ID/EX = 0.
  - mem_busy takes precedence: stall_exmem=1 and drain_cnt holds.
  - Otherwise drain_cnt increments. When drain_cnt==DRAIN_CYCLES-1, next state is HALT.
  - ex_branch_taken and load_use are ignored.
- HALT:
  - halted=1, stall_pc=1, flush_ifid=1, flush_idex=1, stall_exmem=0.
  - Leaves HALT only on rst.
- stall_cycles increments on every cycle with stall_pc=1 (including HALT) until all-ones, then holds.

Decomposition:
- Shared package common_def:
  - hz_state_t enum: RUN=2'd0, MEM_WAIT=2'd1, DRAIN=2'd2, HALT=2'd3.
  - REG_X0=5'd0.
- One sub-module, hazard_detect: the purely combinational load_use comparator. Its inputs are the id_* and ex_rd/ex_memRead signals; its output is load_use.
- The FSM, counters and output decode stay in the top module.

Test Plan:
- Load-use: EX lw x5 (ex_memRead=1, ex_rd=5); ID id_rs2=5, id_uses_rs2=1 -> exactly 1 cycle of stall_pc=stall_ifid=flush_idex=1; stall_cycles=1.
- x0 plus branch priority:
  - ex_rd=0 load with id_rs1=0 -> no stall.
  - load_use together with ex_branch_taken=1 -> flush_ifid=flush_idex=1, stall_pc=0.
- Memory wait: dmem_req=1 with dmem_ack=0 for 4 cycles, then ack -> all stalls=1 for 4 cycles, 0 in the ack cycle, state back to RUN, mem_timeout=0.
- Timeout: MEM_TIMEOUT=3, ack withheld 6 cycles -> mem_timeout=1 from the 3rd wait cycle and still 1 after the ack.
- ECALL: ex_ecall=1 with DRAIN_CYCLES=3 -> flush_ifid=flush_idex=stall_pc=1 for the ECALL cycle plus 3 DRAIN cycles, then halted=1 held for 20 cycles.
- Reset mid-operation: rst=1 during MEM_WAIT or HALT -> the next cycle has all outputs 0, halted=0, stall_cycles=0.
